// File: rtl/ss_scan_capture.sv
// Receive-side decoder for the multiplexed 8-digit seven-segment scan bus.
// Rebuilds the 32-bit BCD word and DP mask from active-low anode/segment/DP lines.
module ss_scan_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  light_code,
    input  logic [6:0]  decode,
    input  logic        DP_out,
    output logic [31:0] data_BCD,
    output logic [7:0]  dp_mask,
    output logic        frame_valid,
    output logic        frame_strobe,
    output logic        code_error
);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_nxt;
    logic [7:0]    r_an;
    logic [7:0]    w_an_nxt;
    logic [6:0]    r_seg;
    logic [6:0]    w_seg_nxt;
    logic [31:0]   r_shadow;
    logic [7:0]    r_shadow_dp;
    logic [7:0]    r_seen;
    logic [7:0]    w_seen_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic [TW-1:0] r_to;
    logic          r_to_hit;
    logic [31:0]   r_data;
    logic [7:0]    r_dp_mask;
    logic          r_valid;
    logic          r_strobe;
    logic          r_code_err;

    logic [7:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic          w_onehot;
    logic          w_err_set;
    logic          w_cap;
    logic [2:0]    w_idx;
    logic [4:0]    w_map;
    logic          w_done;
    logic          w_to_fire;

    assign w_an  = ~r_sync2[15:8];
    assign w_seg = ~r_sync2[7:1];
    assign w_dp  = ~r_sync2[0];

    assign w_onehot  = (w_an != 8'h00) && ((w_an & (w_an - 8'h01)) == 8'h00);
    assign w_done    = (r_seen == 8'hFF);
    assign w_to_fire = (r_to == TO_LAST) && !r_to_hit;

    // {illegal, nibble}
    function automatic logic [4:0] seg_map(input logic [6:0] s);
        case (s)
            7'b1111110: seg_map = 5'h00;
            7'b0110000: seg_map = 5'h01;
            7'b1101101: seg_map = 5'h02;
            7'b1111001: seg_map = 5'h03;
            7'b0110011: seg_map = 5'h04;
            7'b1011011: seg_map = 5'h05;
            7'b0011111: seg_map = 5'h06;
            7'b1110000: seg_map = 5'h07;
            7'b1111111: seg_map = 5'h08;
            7'b1110011: seg_map = 5'h09;
            7'b0000001: seg_map = 5'h0A;
            7'b0111110: seg_map = 5'h0B;
            7'b0000000: seg_map = 5'h0F;
            default:    seg_map = 5'h1F;
        endcase
    endfunction

    assign w_map = seg_map(r_seg);

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_an[i]) w_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {light_code, decode, DP_out};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_an    <= '0;
            r_seg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_an_nxt    = r_an;
        w_seg_nxt   = r_seg;
        w_err_set   = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE, S_SETTLE: begin
                if (r_state == S_IDLE || w_an != r_an || w_seg != r_seg) begin
                    w_cnt_nxt = '0;
                    w_an_nxt  = w_an;
                    w_seg_nxt = w_seg;
                    if (w_onehot) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err_set   = (w_an != 8'h00);
                    end
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                w_cap       = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_an != r_an) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A capture landing on the publish cycle starts the next frame.
    always_comb begin
        w_seen_nxt = r_seen;
        w_err_nxt  = r_err;
        if (w_done || w_to_fire) begin
            w_seen_nxt = '0;
            w_err_nxt  = 1'b0;
        end
        if (w_cap) begin
            w_seen_nxt[w_idx] = 1'b1;
            if (w_map[4]) w_err_nxt = 1'b1;
        end
        if (w_err_set) w_err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_seen      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_seen <= w_seen_nxt;
            r_err  <= w_err_nxt;
            if (w_cap) begin
                r_shadow[4*w_idx +: 4] <= w_map[3:0];
                r_shadow_dp[w_idx]     <= w_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to       <= '0;
            r_to_hit   <= 1'b0;
            r_data     <= '0;
            r_dp_mask  <= '0;
            r_valid    <= 1'b0;
            r_strobe   <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            r_strobe <= w_done;
            if (w_done) begin
                r_data     <= r_shadow;
                r_dp_mask  <= r_shadow_dp;
                r_code_err <= r_err;
                r_valid    <= 1'b1;
                r_to       <= '0;
                r_to_hit   <= 1'b0;
            end else begin
                if (r_to != TO_LAST) r_to <= r_to + 1'b1;
                if (w_to_fire) begin
                    r_valid  <= 1'b0;
                    r_to_hit <= 1'b1;
                end
            end
        end
    end

    assign data_BCD     = r_data;
    assign dp_mask      = r_dp_mask;
    assign frame_valid  = r_valid;
    assign frame_strobe = r_strobe;
    assign code_error   = r_code_err;

endmodule

// File: tb/tb_ss_scan_capture.sv
// Bench for ss_scan_capture: table-driven scans checked by a strobe-side
// scoreboard, plus glitch, multi-hot, timeout and reset sequences.
module tb_ss_scan_capture;
    localparam int SETTLE = 16;
    localparam int TMO    = 1000;
    localparam int HOLD   = 40;
    localparam int GAP    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  light_code;
    logic [6:0]  decode;
    logic        DP_out;
    logic [31:0] data_BCD;
    logic [7:0]  dp_mask;
    logic        frame_valid;
    logic        frame_strobe;
    logic        code_error;

    always #5 clk = ~clk;

    ss_scan_capture #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .light_code  (light_code),
        .decode      (decode),
        .DP_out      (DP_out),
        .data_BCD    (data_BCD),
        .dp_mask     (dp_mask),
        .frame_valid (frame_valid),
        .frame_strobe(frame_strobe),
        .code_error  (code_error)
    );

    typedef struct packed {
        logic [31:0] bcd;
        logic [7:0]  dp;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [55:0] segs;
        logic [7:0]  dp;
        logic [31:0] bcd;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    exp_t m_e;
    vec_t vecs[4];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   n_strobe = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [6:0] enc(logic [3:0] d);
        case (d)
            4'h0:    enc = 7'b1111110;
            4'h1:    enc = 7'b0110000;
            4'h2:    enc = 7'b1101101;
            4'h3:    enc = 7'b1111001;
            4'h4:    enc = 7'b0110011;
            4'h5:    enc = 7'b1011011;
            4'h6:    enc = 7'b0011111;
            4'h7:    enc = 7'b1110000;
            4'h8:    enc = 7'b1111111;
            4'h9:    enc = 7'b1110011;
            4'hA:    enc = 7'b0000001;
            4'hB:    enc = 7'b0111110;
            default: enc = 7'b0000000;
        endcase
    endfunction

    function automatic logic [55:0] enc_word(logic [31:0] w);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = enc(w[4*i +: 4]);
        return r;
    endfunction

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && frame_strobe) begin
            n_strobe++;
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                m_e = exp_q.pop_front();
                check("data_BCD", data_BCD, m_e.bcd);
                check("dp_mask", 32'(dp_mask), 32'(m_e.dp));
                check("code_error", 32'(code_error), 32'(m_e.err));
                check("frame_valid", 32'(frame_valid), 32'd1);
            end
        end
    end

    task automatic blank(int n);
        light_code = 8'hFF;
        decode     = 7'h7F;
        DP_out     = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_digit(int i, logic [6:0] seg, logic dp, int hold);
        light_code = ~(8'd1 << i);
        decode     = ~seg;
        DP_out     = ~dp;
        repeat (hold) @(negedge clk);
    endtask

    task automatic scan(logic [55:0] segs, logic [7:0] dp, int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            drive_digit(i, segs[7*i +: 7], dp[i], HOLD);
            blank(GAP);
        end
    endtask

    task automatic wait_strobe(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_strobe && n < limit);
    endtask

    initial begin
        logic [55:0] s;
        int          n;
        int          cnt0;

        rst_n      = 1'b0;
        light_code = 8'hFF;
        decode     = 7'h7F;
        DP_out     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data_BCD, 32'h0);
        check("rst_dp", 32'(dp_mask), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_strobe", 32'(frame_strobe), 32'h0);
        check("rst_err", 32'(code_error), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{enc_word(32'h12345678), 8'h00, 32'h12345678, 1'b0};
        vecs[1] = '{enc_word(32'h12F4A678), 8'h04, 32'h12F4A678, 1'b0};
        vecs[2] = '{enc_word(32'h876F4321), 8'hA0, 32'h876F4321, 1'b1};
        vecs[2].segs[34:28] = 7'b1010101;
        vecs[3] = '{enc_word(32'hB0B9A8F1), 8'hFF, 32'hB0B9A8F1, 1'b0};

        for (int v = 0; v < 4; v++) begin
            exp_q.push_back('{vecs[v].bcd, vecs[v].dp, vecs[v].err});
            scan(vecs[v].segs, vecs[v].dp, 0, 7);
        end

        // Glitch on the last digit: the strobe must follow the clean pattern.
        s = enc_word(32'h12345678);
        exp_q.push_back('{32'h12345678, 8'h00, 1'b0});
        scan(s, 8'h00, 0, 6);
        drive_digit(7, s[55:49], 1'b0, 10);
        decode = ~7'b1111111;
        repeat (5) @(negedge clk);
        decode = ~s[55:49];
        wait_strobe(n, 60);
        check("glitch_latency", 32'(n), 32'd21);
        repeat (20) @(negedge clk);
        blank(GAP);

        // Multi-hot anodes taint the next frame only.
        light_code = ~8'b0000_0011;
        decode     = ~enc(4'h5);
        repeat (30) @(negedge clk);
        blank(GAP);
        exp_q.push_back('{32'h12345678, 8'h00, 1'b1});
        scan(s, 8'h00, 0, 7);
        exp_q.push_back('{32'h12345678, 8'h00, 1'b0});
        scan(s, 8'h00, 0, 7);

        // Timeout after the last frame; published data is held.
        s = enc_word(32'h00112233);
        exp_q.push_back('{32'h00112233, 8'h81, 1'b0});
        scan(s, 8'h81, 0, 6);
        light_code = ~8'h80;
        decode     = ~s[55:49];
        DP_out     = 1'b0;
        wait_strobe(n, 60);
        check("strobe_before_timeout", 32'(frame_strobe), 32'd1);
        blank(0);
        n = 0;
        while (frame_valid && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd1000);
        check("hold_data", data_BCD, 32'h00112233);
        check("hold_dp", 32'(dp_mask), 32'h81);

        // Reset mid-scan throws away the partial frame.
        s = enc_word(32'h56781234);
        scan(s, 8'h0F, 0, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_BCD, 32'h0);
        check("mid_rst_dp", 32'(dp_mask), 32'h0);
        check("mid_rst_valid", 32'(frame_valid), 32'h0);
        check("mid_rst_err", 32'(code_error), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cnt0 = n_strobe;
        scan(s, 8'h0F, 4, 7);
        check("no_strobe_partial", 32'(n_strobe - cnt0), 32'd0);
        exp_q.push_back('{32'h56781234, 8'h0F, 1'b0});
        scan(s, 8'h0F, 0, 3);
        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("strobe_count_after_rst", 32'(n_strobe - cnt0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
